uart_rx_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO that buffers 32-bit words assembled by the UART controller's receive path until the system controller reads them. The write side connects directly to the controller's `rx_data`/`rx_fifo_en`/`rx_full` signals. The read side presents the oldest word to the controller continuously. The controller pulses `wr_en` without checking `full`, so the FIFO detects and flags overflow.

---
 rtl/uart_rx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO between the UART receive assembler and the system controller.
// The head word is on rd_data with zero read latency; writes that arrive while full are dropped and flagged.
module uart_rx_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic wr_acc;
  logic rd_acc;
  logic wr_drop;
  logic rd_bad;

  // A full FIFO still takes a write when the same cycle pops, so level stays at DEPTH.
  assign wr_acc  = wr_en && (!full_q || rd_en);
  assign wr_drop = wr_en && full_q && !rd_en;
  assign rd_acc  = rd_en && !empty_q;
  assign rd_bad  = rd_en && empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (wr_acc && !rd_acc) begin
      level_d = level_q + LW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - LW'(1);
    end

    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
    afull_d = (level_d >= LW'(AFULL_LVL));
  end

  // A new error event in the clearing cycle keeps its flag set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_drop) begin
      overflow_d = 1'b1;
    end
    if (rd_bad) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data     = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = afull_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: each task drives one scenario and checks hand-computed values.
module tb_uart_rx_fifo;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        almost_full;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        empty;
  logic [4:0]  level;
  logic        overflow;
  logic        underflow;
  logic        clr_err;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.DATA_W(32), .DEPTH(16), .AFULL_LVL(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; rst = 1'b0; wr_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hFFFF_FFFF;
    step();
    idle();
    total++;
    if ({empty, full, almost_full, overflow, underflow} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags got %b want 10000", {empty, full, almost_full, overflow, underflow});
    end
    total++;
    if (level !== 5'd0) begin bad++; $display("FAIL reset_level got %0d want 0", level); end
    total++;
    if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
  endtask

  task automatic test_basic();
    logic [31:0] vals [3];
    vals[0] = 32'h1111_1111; vals[1] = 32'h2222_2222; vals[2] = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = vals[i];
      step();
      total++;
      if (level !== 5'(i + 1)) begin bad++; $display("FAIL basic_wr_level got %0d want %0d", level, i + 1); end
      total++;
      if (rd_data !== vals[0] || empty !== 1'b0) begin
        bad++; $display("FAIL basic_head got %h empty %b want %h empty 0", rd_data, empty, vals[0]);
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rd_data !== vals[i]) begin bad++; $display("FAIL basic_rd_data got %h want %h", rd_data, vals[i]); end
      rd_en = 1'b1;
      step();
      total++;
      if (level !== 5'(2 - i)) begin bad++; $display("FAIL basic_rd_level got %0d want %0d", level, 2 - i); end
    end
    rd_en = 1'b0;
    total++;
    if (rd_data !== 32'h0 || empty !== 1'b1) begin
      bad++; $display("FAIL basic_drained got %h empty %b want 0 empty 1", rd_data, empty);
    end
  endtask

  task automatic test_fill_overflow();
    for (int k = 1; k <= 16; k++) begin
      wr_en = 1'b1; wr_data = 32'(k - 1);
      step();
      total++;
      if (almost_full !== (k >= 12) || full !== (k == 16)) begin
        bad++; $display("FAIL fill_flags after write %0d got afull %b full %b want %b %b",
                        k, almost_full, full, k >= 12, k == 16);
      end
    end
    wr_data = 32'hDEAD_BEEF;
    step();
    wr_en = 1'b0;
    total++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      bad++; $display("FAIL fill_drop got overflow %b level %0d want 1 16", overflow, level);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rd_data !== 32'(i)) begin bad++; $display("FAIL fill_readout got %h want %h", rd_data, 32'(i)); end
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      bad++; $display("FAIL fill_empty got empty %b full %b afull %b want 1 0 0", empty, full, almost_full);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL fill_clr got overflow %b want 0", overflow); end
  endtask

  task automatic test_full_rw();
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 32'h100 + 32'(i);
      step();
    end
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hA5A5_A5A5;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    total++;
    if (level !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
      bad++; $display("FAIL fullrw_state got level %0d overflow %b full %b want 16 0 1", level, overflow, full);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 32'hA5A5_A5A5 : 32'h101 + 32'(i);
      total++;
      if (rd_data !== exp) begin bad++; $display("FAIL fullrw_readout got %h want %h", rd_data, exp); end
      rd_en = 1'b1;
      step();
      if (i == 0) begin
        total++;
        if (full !== 1'b0) begin bad++; $display("FAIL fullrw_full_drop got %b want 0", full); end
      end
    end
    rd_en = 1'b0;
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL fullrw_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    wr_en = 1'b1; wr_data = 32'h1000;
    step();
    for (int i = 0; i < 40; i++) begin
      exp = (i == 0) ? 32'h1000 : 32'h2000 + 32'(i - 1);
      total++;
      if (rd_data !== exp) begin bad++; $display("FAIL b2b_data cycle %0d got %h want %h", i, rd_data, exp); end
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h2000 + 32'(i);
      step();
      total++;
      if (level !== 5'd1) begin bad++; $display("FAIL b2b_level cycle %0d got %0d want 1", i, level); end
    end
    wr_en = 1'b0; rd_en = 1'b1;
    total++;
    if (rd_data !== 32'h2027) begin bad++; $display("FAIL b2b_last got %h want 00002027", rd_data); end
    step();
    rd_en = 1'b0;
    total++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      bad++; $display("FAIL b2b_end got empty %b underflow %b want 1 0", empty, underflow);
    end
  endtask

  task automatic test_underflow_clr();
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h0000_CAFE;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    total++;
    if (underflow !== 1'b1 || level !== 5'd1 || rd_data !== 32'h0000_CAFE) begin
      bad++; $display("FAIL uflow got underflow %b level %0d data %h want 1 1 0000cafe", underflow, level, rd_data);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    total++;
    if (underflow !== 1'b0 || overflow !== 1'b0 || level !== 5'd1) begin
      bad++; $display("FAIL uflow_clr got uf %b of %b level %0d want 0 0 1", underflow, overflow, level);
    end
    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_data = 32'h300 + 32'(i);
      step();
    end
    wr_en = 1'b1; clr_err = 1'b1; wr_data = 32'hBAD0_BAD0;
    step();
    wr_en = 1'b0; clr_err = 1'b0;
    total++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      bad++; $display("FAIL clr_vs_drop got overflow %b level %0d want 1 16", overflow, level);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 11; i++) begin
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    total++;
    if (level !== 5'd5 || rd_data !== 32'h30A) begin
      bad++; $display("FAIL midrst_pre got level %0d data %h want 5 0000030a", level, rd_data);
    end
    rst = 1'b1; wr_en = 1'b1; wr_data = 32'h5555_5555;
    step();
    rst = 1'b0; wr_en = 1'b0;
    total++;
    if ({empty, full, almost_full, overflow, underflow} !== 5'b10000 || level !== 5'd0 || rd_data !== 32'h0) begin
      bad++; $display("FAIL midrst got flags %b level %0d data %h want 10000 0 0",
                      {empty, full, almost_full, overflow, underflow}, level, rd_data);
    end
    wr_en = 1'b1; wr_data = 32'h1234_5678;
    step();
    wr_en = 1'b0;
    total++;
    if (rd_data !== 32'h1234_5678 || level !== 5'd1) begin
      bad++; $display("FAIL midrst_first got %h level %0d want 12345678 1", rd_data, level);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_rw();
    test_back_to_back();
    test_underflow_clr();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
